multi_packet_eject: RTL and testbench
=====================================

Name: multi_packet_eject

Overview:
Local ejection receiver at each mesh node, the destination end of the fan-out path. The source-side packet generator fans one multicast/broadcast request out into per-node copies. This block accepts those copies and unicasts from the router's local output port. It filters misrouted and duplicate copies, buffers survivors in a small FIFO, and hands them to the local core over a valid/ready interface, with delivery and error counters.

Parameters:
LOCAL_X, 3'd0, node X coordinate (0-7)
LOCAL_Y, 3'd0, node Y coordinate (0-7)
DATA_W, 32, payload width
DEPTH, 2, FIFO depth; power of two, >=2

Ports:
clk  in  1  clock, single domain
rst_n  in  1  reset, synchronous, active-low
in_vld  in  1  router local-port packet valid
in_rdy  out  1  block can accept
in_pkt_type  in  2  00 unicast, 01 column multicast, 10 row multicast, 11 broadcast
in_tgt  in  6  copy target {y[5:3],x[2:0]}
in_src  in  6  originating node {y,x}
in_seq  in  4  source sequence id
in_data  in  DATA_W  payload
out_vld  out  1  packet available to core
out_rdy  in  1  core accepts
out_pkt_type  out  2  head packet type
out_src  out  6  head packet source
out_data  out  DATA_W  head payload
drop_mis  out  1  one-cycle pulse: misrouted copy dropped
drop_dup  out  1  one-cycle pulse: duplicate copy dropped
rx_cnt  out  16  delivered-packet count, wraps
err_cnt  out  8  misroute+duplicate count, saturates at 255

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO empty, out_vld=0, in_rdy=1 in the cycle after reset, drop_mis=0, drop_dup=0, rx_cnt=0, err_cnt=0, dedup record invalid. out_* data fields are don't-care while out_vld=0. Reset mid-operation discards all buffered packets.
- in_rdy = !full; registered-state only, never combinational from out_rdy or in_*.
- Accept event: in_vld & in_rdy. Classification is applied to every accepted packet, in priority order:
  1. Misroute: in_tgt != {LOCAL_Y,LOCAL_X}. Drop, drop_mis=1 next cycle, err_cnt+1 (saturating).
  2. Duplicate: in_pkt_type != 00, record valid, and {in_src,in_seq,in_pkt_type} equals the stored record. Drop, drop_dup=1 next cycle, err_cnt+1.
  3. Otherwise push into the FIFO. If the type is != 00, load the record with {in_src,in_seq,in_pkt_type} and set it valid.
- Unicast never reads or updates the dedup record.
- A full FIFO deasserts in_rdy even for packets that would be dropped; no bypass.
- Latency: a pushed packet is visible on out_* with out_vld=1 the cycle after acceptance; no same-cycle passthrough.
- Pop event: out_vld & out_rdy. Advances the head; rx_cnt+1 (wraps 16'hFFFF->0).
- Simultaneous push and pop (not full, not empty): occupancy unchanged, order preserved.
- Pop on the full FIFO frees a slot; in_rdy rises the next cycle.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH, plus a separate occupancy count 0..DEPTH.
- out_* hold stable while out_vld=1 and out_rdy=0.
- drop_mis and drop_dup are registered pulses, mutually exclusive, low when no drop occurs.

Decomposition:
- Shared package mesh_pkg: PKT_UNI=2'b00, PKT_COL=2'b01, PKT_ROW=2'b10, PKT_BC=2'b11; COORD_W=3, NODE_W=6, SEQ_W=4. The generator and this block both import it.
- One sub-module, eject_fifo: parameterised DEPTH/width synchronous FIFO with the same synchronous active-low reset, push/pop/full/empty. Classification, dedup record and counters stay in the top.

Test Plan:
(LOCAL_X=3, LOCAL_Y=5, local id 6'h2B, DEPTH=2)
1. Reset, then unicast tgt=2B src=01 data=A5A5A5A5, out_rdy=1 -> out_vld=1 next cycle with data A5A5A5A5, src 01; rx_cnt=1; no drop pulses.
2. Broadcast tgt=2B src=07 seq=3, then the same copy again -> first delivered; second gives drop_dup=1 for one cycle, err_cnt=1, rx_cnt=1. Then seq=4 -> delivered.
3. Row multicast tgt=2A (x mismatch) -> drop_mis=1, err_cnt=1, out_vld stays 0.
4. out_rdy=0, push 3 unicasts back-to-back -> in_rdy=0 after the 2nd accept; 3rd held. Raise out_rdy -> packets 1,2,3 emerge in order; in_rdy recovers the cycle after the first pop.
5. 300 misrouted packets -> err_cnt saturates at 255, no wrap.
6. FIFO holding 2 packets, assert rst_n=0 for one edge -> out_vld=0, in_rdy=1, counters 0, dedup cleared: a repeat of the pre-reset broadcast {src,seq} is delivered, not dropped.

Source files
------------

// File: rtl/mesh_pkg.sv
// Mesh-wide packet types, coordinate widths and dedup key layout shared by the
// fan-out generator and the ejection receiver.
package mesh_pkg;
  localparam int COORD_W = 3;
  localparam int NODE_W  = 2 * COORD_W;
  localparam int SEQ_W   = 4;

  typedef enum logic [1:0] {
    PKT_UNI = 2'b00,
    PKT_COL = 2'b01,
    PKT_ROW = 2'b10,
    PKT_BC  = 2'b11
  } pkt_type_e;

  typedef struct packed {
    logic [NODE_W-1:0] src;
    logic [SEQ_W-1:0]  seq;
    pkt_type_e         pkt_type;
  } dedup_key_t;

  function automatic logic [NODE_W-1:0] node_id(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction
endpackage

// File: rtl/multi_packet_eject_if.sv
// Router-local-port ingress and core-facing egress of the ejection receiver;
// both sides are valid/ready.
interface multi_packet_eject_if #(parameter int DATA_W = 32);
  import mesh_pkg::*;

  logic              in_vld;
  logic              in_rdy;
  logic [1:0]        in_pkt_type;
  logic [NODE_W-1:0] in_tgt;
  logic [NODE_W-1:0] in_src;
  logic [SEQ_W-1:0]  in_seq;
  logic [DATA_W-1:0] in_data;

  logic              out_vld;
  logic              out_rdy;
  logic [1:0]        out_pkt_type;
  logic [NODE_W-1:0] out_src;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_vld, in_pkt_type, in_tgt, in_src, in_seq, in_data, out_rdy,
    input  in_rdy, out_vld, out_pkt_type, out_src, out_data
  );

  modport slave (
    input  in_vld, in_pkt_type, in_tgt, in_src, in_seq, in_data, out_rdy,
    output in_rdy, out_vld, out_pkt_type, out_src, out_data
  );
endinterface

// File: rtl/eject_fifo.sv
// Synchronous FIFO, one-cycle push-to-head latency, no passthrough; push is
// ignored when full, pop ignored when empty (callers gate on full/empty).
module eject_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o     = (cnt_q == CNT_FULL);
  assign empty_o    = (cnt_q == '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/multi_packet_eject.sv
// Node ejection receiver: drops misrouted/duplicate copies, buffers the rest,
// delivers one cycle after accept; in_rdy tracks FIFO fullness only.
module multi_packet_eject
  import mesh_pkg::*;
#(
  parameter logic [COORD_W-1:0] LOCAL_X = 3'd0,
  parameter logic [COORD_W-1:0] LOCAL_Y = 3'd0,
  parameter int                 DATA_W  = 32,
  parameter int                 DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_packet_eject_if.slave  bus,
  output logic                 drop_mis,
  output logic                 drop_dup,
  output logic [15:0]          rx_cnt,
  output logic [7:0]           err_cnt
);
  localparam int ENTRY_W = 2 + NODE_W + DATA_W;

  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head_dat;
  logic               accept, pop, push;
  logic               is_local, is_mcast, is_dup;
  dedup_key_t         in_key;

  dedup_key_t rec_q, rec_d;
  logic       rec_vld_q, rec_vld_d;
  logic       drop_mis_q, drop_mis_d;
  logic       drop_dup_q, drop_dup_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  assign bus.in_rdy  = ~fifo_full;
  assign bus.out_vld = ~fifo_empty;
  assign {bus.out_pkt_type, bus.out_src, bus.out_data} = head_dat;

  assign drop_mis = drop_mis_q;
  assign drop_dup = drop_dup_q;
  assign rx_cnt   = rx_cnt_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    accept   = bus.in_vld & ~fifo_full;
    pop      = ~fifo_empty & bus.out_rdy;
    in_key   = '{src: bus.in_src, seq: bus.in_seq, pkt_type: pkt_type_e'(bus.in_pkt_type)};
    is_local = (bus.in_tgt == node_id(LOCAL_X, LOCAL_Y));
    is_mcast = (pkt_type_e'(bus.in_pkt_type) != PKT_UNI);
    // Unicast bypasses the record entirely: it neither matches nor reloads it.
    is_dup   = is_mcast & rec_vld_q & (in_key == rec_q);

    drop_mis_d = accept & ~is_local;
    drop_dup_d = accept & is_local & is_dup;
    push       = accept & is_local & ~is_dup;

    rec_d     = rec_q;
    rec_vld_d = rec_vld_q;
    if (push && is_mcast) begin
      rec_d     = in_key;
      rec_vld_d = 1'b1;
    end

    rx_cnt_d = pop ? rx_cnt_q + 16'd1 : rx_cnt_q;

    err_cnt_d = err_cnt_q;
    if ((drop_mis_d || drop_dup_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_q      <= '0;
      rec_vld_q  <= 1'b0;
      drop_mis_q <= 1'b0;
      drop_dup_q <= 1'b0;
      rx_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      rec_q      <= rec_d;
      rec_vld_q  <= rec_vld_d;
      drop_mis_q <= drop_mis_d;
      drop_dup_q <= drop_dup_d;
      rx_cnt_q   <= rx_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  eject_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i ({bus.in_pkt_type, bus.in_src, bus.in_data}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );
endmodule

// File: tb/tb_multi_packet_eject.sv
// Bench for the ejection receiver at node (x=3,y=5): queue-level reference model
// compared every cycle, plus directed literal expectations.
module tb_multi_packet_eject;
  import mesh_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam logic [5:0] LOCAL_ID = 6'h2B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        drop_mis, drop_dup;
  logic [15:0] rx_cnt;
  logic [7:0]  err_cnt;

  multi_packet_eject_if #(.DATA_W(DATA_W)) bus ();

  multi_packet_eject #(
    .LOCAL_X (3'd3),
    .LOCAL_Y (3'd5),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop_mis (drop_mis),
    .drop_dup (drop_dup),
    .rx_cnt   (rx_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of delivered-but-not-consumed packets plus counters.
  typedef struct {
    logic [1:0]  t;
    logic [5:0]  src;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          mdl_ok = 0;
  bit          m_mis, m_dup, m_rec_vld;
  logic [15:0] m_rx;
  int          m_err;
  logic [5:0]  m_rsrc;
  logic [3:0]  m_rseq;
  logic [1:0]  m_rtype;

  always @(posedge clk) begin : model
    bit   acc;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_mis = 0; m_dup = 0; m_rec_vld = 0;
      m_rx = '0; m_err = 0;
      mdl_ok = 1;
    end else if (mdl_ok) begin
      acc = bus.in_vld && (mq.size() < DEPTH);
      m_mis = 0;
      m_dup = 0;
      if (mq.size() > 0 && bus.out_rdy) begin
        void'(mq.pop_front());
        m_rx = m_rx + 16'd1;
      end
      if (acc) begin
        if (bus.in_tgt != LOCAL_ID) begin
          m_mis = 1;
          if (m_err < 255) m_err++;
        end else if (bus.in_pkt_type != 2'b00 && m_rec_vld &&
                     {bus.in_src, bus.in_seq, bus.in_pkt_type} == {m_rsrc, m_rseq, m_rtype}) begin
          m_dup = 1;
          if (m_err < 255) m_err++;
        end else begin
          e.t = bus.in_pkt_type; e.src = bus.in_src; e.data = bus.in_data;
          mq.push_back(e);
          if (bus.in_pkt_type != 2'b00) begin
            m_rec_vld = 1;
            m_rsrc = bus.in_src; m_rseq = bus.in_seq; m_rtype = bus.in_pkt_type;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      check("in_rdy", 64'(bus.in_rdy), 64'(mq.size() < DEPTH));
      check("out_vld", 64'(bus.out_vld), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("out_data", 64'(bus.out_data), 64'(mq[0].data));
        check("out_src", 64'(bus.out_src), 64'(mq[0].src));
        check("out_pkt_type", 64'(bus.out_pkt_type), 64'(mq[0].t));
      end
      check("drop_mis", 64'(drop_mis), 64'(m_mis));
      check("drop_dup", 64'(drop_dup), 64'(m_dup));
      check("rx_cnt", 64'(rx_cnt), 64'(m_rx));
      check("err_cnt", 64'(err_cnt), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a packet and returns #1 after the edge that accepted it; in_vld stays high.
  task automatic send(input logic [1:0] t, input logic [5:0] tgt, input logic [5:0] src,
                      input logic [3:0] seq, input logic [31:0] d);
    bit done = 0;
    bus.in_vld = 1'b1;
    bus.in_pkt_type = t;
    bus.in_tgt = tgt;
    bus.in_src = src;
    bus.in_seq = seq;
    bus.in_data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_rdy) done = 1;
      tick();
    end
    check("send_accept", 64'(done), 64'd1);
  endtask

  task automatic idle();
    bus.in_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.in_vld = 1'b0;
    bus.in_pkt_type = 2'b00;
    bus.in_tgt = '0;
    bus.in_src = '0;
    bus.in_seq = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_in_rdy", 64'(bus.in_rdy), 64'd1);
    check("rst_out_vld", 64'(bus.out_vld), 64'd0);
    check("rst_drops", 64'({drop_mis, drop_dup}), 64'd0);
    check("rst_rx", 64'(rx_cnt), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);

    // Unicast delivery
    bus.out_rdy = 1'b1;
    send(PKT_UNI, 6'h2B, 6'h01, 4'd0, 32'hA5A5A5A5);
    idle();
    check("t1_vld", 64'(bus.out_vld), 64'd1);
    check("t1_data", 64'(bus.out_data), 64'hA5A5A5A5);
    check("t1_src", 64'(bus.out_src), 64'h01);
    tick();
    check("t1_rx", 64'(rx_cnt), 64'd1);
    check("t1_drop", 64'({drop_mis, drop_dup}), 64'd0);

    // Broadcast duplicate suppression
    send(PKT_BC, 6'h2B, 6'h07, 4'd3, 32'h0000B003);
    send(PKT_BC, 6'h2B, 6'h07, 4'd3, 32'h0000B0D3);
    idle();
    check("t2_dup", 64'(drop_dup), 64'd1);
    check("t2_err", 64'(err_cnt), 64'd1);
    check("t2_rx", 64'(rx_cnt), 64'd2);
    tick();
    check("t2_dup_clr", 64'(drop_dup), 64'd0);
    send(PKT_BC, 6'h2B, 6'h07, 4'd4, 32'h0000B004);
    idle();
    check("t2_seq4_vld", 64'(bus.out_vld), 64'd1);
    check("t2_seq4_data", 64'(bus.out_data), 64'h0000B004);
    tick();
    check("t2_rx3", 64'(rx_cnt), 64'd3);

    // Misroute
    send(PKT_ROW, 6'h2A, 6'h07, 4'd5, 32'h0000DEAD);
    idle();
    check("t3_mis", 64'(drop_mis), 64'd1);
    check("t3_err", 64'(err_cnt), 64'd2);
    check("t3_vld", 64'(bus.out_vld), 64'd0);
    tick();
    check("t3_mis_clr", 64'(drop_mis), 64'd0);

    // Backpressure and ordering
    bus.out_rdy = 1'b0;
    send(PKT_UNI, 6'h2B, 6'h01, 4'd0, 32'h11111111);
    send(PKT_UNI, 6'h2B, 6'h02, 4'd0, 32'h22222222);
    check("t4_full", 64'(bus.in_rdy), 64'd0);
    bus.in_src = 6'h03;
    bus.in_data = 32'h33333333;
    tick();
    tick();
    check("t4_held", 64'(bus.in_rdy), 64'd0);
    check("t4_head1", 64'(bus.out_data), 64'h11111111);
    bus.out_rdy = 1'b1;
    tick();
    check("t4_rdy_back", 64'(bus.in_rdy), 64'd1);
    check("t4_head2", 64'(bus.out_data), 64'h22222222);
    check("t4_rx4", 64'(rx_cnt), 64'd4);
    tick();
    idle();
    check("t4_head3", 64'(bus.out_data), 64'h33333333);
    check("t4_rx5", 64'(rx_cnt), 64'd5);
    tick();
    check("t4_rx6", 64'(rx_cnt), 64'd6);
    check("t4_empty", 64'(bus.out_vld), 64'd0);

    // Error counter saturation
    bus.in_vld = 1'b1;
    bus.in_pkt_type = PKT_UNI;
    bus.in_tgt = 6'h00;
    for (int i = 0; i < 300; i++) tick();
    idle();
    check("t5_sat", 64'(err_cnt), 64'd255);
    check("t5_mis", 64'(drop_mis), 64'd1);
    tick();
    check("t5_sat_hold", 64'(err_cnt), 64'd255);

    // Reset with a full FIFO clears data, counters and dedup record
    bus.out_rdy = 1'b0;
    send(PKT_BC, 6'h2B, 6'h12, 4'd9, 32'hCAFE0001);
    send(PKT_UNI, 6'h2B, 6'h01, 4'd0, 32'hCAFE0002);
    idle();
    check("t6_full_vld", 64'(bus.out_vld), 64'd1);
    check("t6_full_rdy", 64'(bus.in_rdy), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_rst_vld", 64'(bus.out_vld), 64'd0);
    check("t6_rst_rdy", 64'(bus.in_rdy), 64'd1);
    check("t6_rst_rx", 64'(rx_cnt), 64'd0);
    check("t6_rst_err", 64'(err_cnt), 64'd0);
    bus.out_rdy = 1'b1;
    send(PKT_BC, 6'h2B, 6'h12, 4'd9, 32'hCAFE0003);
    idle();
    check("t6_no_dup", 64'(drop_dup), 64'd0);
    check("t6_vld", 64'(bus.out_vld), 64'd1);
    check("t6_data", 64'(bus.out_data), 64'hCAFE0003);
    tick();
    check("t6_rx", 64'(rx_cnt), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
